// File: rtl/serial_mult_ctrl.sv
// Sequencer for a shift-add serial multiplier datapath: accept, load, WL shift/add steps, capture, hold.
// Optional SMUL_EARLY_EXIT_EN: leave RUN as soon as the datapath reports the multiplier exhausted.
module serial_mult_ctrl #(
    parameter int unsigned WL = 4
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  IN_VALID,
    output logic                  IN_READY,
    input  logic [WL-1:0]         OP_A,
    input  logic [WL-1:0]         OP_B,
    input  logic                  ABORT,
    output logic                  OUT_VALID,
    input  logic                  OUT_READY,
    output logic [2*WL-1:0]       RESULT,
    output logic [2*WL-1:0]       DP_A,
    output logic [2*WL-1:0]       DP_B,
    output logic                  DP_LOAD,
    output logic                  DP_CLR,
    output logic                  DP_ADD,
    output logic                  DP_SHIFT,
    input  logic                  DP_LSB,
    input  logic                  DP_BZERO,
    input  logic [2*WL-1:0]       DP_PRODUCT,
    output logic [$clog2(WL):0]   ITERS
);

    localparam int unsigned PW = 2 * WL;
    localparam int unsigned CW = $clog2(WL) + 1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_RUN     = 3'd2,
        S_CAPTURE = 3'd3,
        S_DONE    = 3'd4
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [CW-1:0]   iters_q, iters_d;
    logic [PW-1:0]   dp_a_q, dp_a_d;
    logic [PW-1:0]   dp_b_q, dp_b_d;
    logic [PW-1:0]   result_q, result_d;
    logic            in_ready_q, in_ready_d;
    logic            out_valid_q, out_valid_d;
    logic            dp_load_q, dp_load_d;
    logic            dp_clr_q, dp_clr_d;
    logic            run_step;
    logic            exit_early;

`ifdef SMUL_EARLY_EXIT_EN
    assign exit_early = DP_BZERO;
`else
    logic unused_bzero;
    assign unused_bzero = DP_BZERO;
    assign exit_early   = 1'b0;
`endif

    // State and registered outputs
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            iters_q     <= '0;
            dp_a_q      <= '0;
            dp_b_q      <= '0;
            result_q    <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            dp_load_q   <= 1'b0;
            dp_clr_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            iters_q     <= iters_d;
            dp_a_q      <= dp_a_d;
            dp_b_q      <= dp_b_d;
            result_q    <= result_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            dp_load_q   <= dp_load_d;
            dp_clr_q    <= dp_clr_d;
        end
    end

    // Next state, latches and Moore decodes of the next state
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        iters_d  = iters_q;
        dp_a_d   = dp_a_q;
        dp_b_d   = dp_b_q;
        result_d = result_q;
        run_step = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (IN_VALID) begin
                    dp_a_d  = PW'(OP_A);
                    dp_b_d  = PW'(OP_B);
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                cnt_d   = '0;
                state_d = S_RUN;
            end
            S_RUN: begin
                if (exit_early) begin
                    state_d = S_CAPTURE;
                end else begin
                    run_step = 1'b1;
                    cnt_d    = cnt_q + CW'(1);
                    if (cnt_q == CW'(WL - 1)) begin
                        state_d = S_CAPTURE;
                    end
                end
            end
            S_CAPTURE: begin
                result_d = DP_PRODUCT;
                iters_d  = cnt_q;
                state_d  = S_DONE;
            end
            S_DONE: begin
                if (OUT_READY) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Abort wins over every transition and leaves latched data untouched
        if (ABORT) begin
            state_d  = S_IDLE;
            dp_a_d   = dp_a_q;
            dp_b_d   = dp_b_q;
            result_d = result_q;
            iters_d  = iters_q;
        end

        in_ready_d  = (state_d == S_IDLE);
        out_valid_d = (state_d == S_DONE);
        dp_load_d   = (state_d == S_LOAD);
        dp_clr_d    = (state_d == S_LOAD);
    end

    assign IN_READY  = in_ready_q;
    assign OUT_VALID = out_valid_q;
    assign RESULT    = result_q;
    assign DP_A      = dp_a_q;
    assign DP_B      = dp_b_q;
    assign DP_LOAD   = dp_load_q;
    assign DP_CLR    = dp_clr_q;
    assign ITERS     = iters_q;
    // Step strobes depend on the live multiplier bits, so they stay combinational
    assign DP_SHIFT  = run_step;
    assign DP_ADD    = run_step & DP_LSB;

endmodule

// File: tb/tb_serial_mult_ctrl.sv
// Bench for serial_mult_ctrl: behavioural datapath, directed and random operations, abort and reset cases.
module tb_serial_mult_ctrl;

    localparam int unsigned WL = 4;
    localparam int unsigned PW = 2 * WL;
    localparam int unsigned CW = $clog2(WL) + 1;

    logic          CLK = 1'b0;
    logic          RST_N;
    logic          IN_VALID, IN_READY, ABORT, OUT_VALID, OUT_READY;
    logic [WL-1:0] OP_A, OP_B;
    logic [PW-1:0] RESULT, DP_A, DP_B, DP_PRODUCT;
    logic          DP_LOAD, DP_CLR, DP_ADD, DP_SHIFT, DP_LSB, DP_BZERO;
    logic [CW-1:0] ITERS;

    int n_vec = 0;
    int n_err = 0;
    logic [PW-1:0] last_res;
    logic [CW-1:0] last_iters;
    logic [PW-1:0] last_a, last_b;

    always #5 CLK = ~CLK;

    serial_mult_ctrl #(.WL(WL)) dut (
        .CLK(CLK), .RST_N(RST_N), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .OP_A(OP_A), .OP_B(OP_B), .ABORT(ABORT), .OUT_VALID(OUT_VALID),
        .OUT_READY(OUT_READY), .RESULT(RESULT), .DP_A(DP_A), .DP_B(DP_B),
        .DP_LOAD(DP_LOAD), .DP_CLR(DP_CLR), .DP_ADD(DP_ADD), .DP_SHIFT(DP_SHIFT),
        .DP_LSB(DP_LSB), .DP_BZERO(DP_BZERO), .DP_PRODUCT(DP_PRODUCT), .ITERS(ITERS)
    );

    // Behavioural shift-add datapath driven by the controller strobes
    logic [PW-1:0] m_mcand, m_mplier, m_prod;
    always @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            m_mcand  <= '0;
            m_mplier <= '0;
            m_prod   <= '0;
        end else begin
            if (DP_LOAD) begin
                m_mcand  <= DP_A;
                m_mplier <= DP_B;
            end
            if (DP_CLR)      m_prod <= '0;
            else if (DP_ADD) m_prod <= m_prod + m_mcand;
            if (DP_SHIFT) begin
                m_mcand  <= m_mcand << 1;
                m_mplier <= m_mplier >> 1;
            end
        end
    end
    assign DP_LSB     = m_mplier[0];
    assign DP_BZERO   = (m_mplier == '0);
    assign DP_PRODUCT = m_prod;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int sig_bits(input logic [WL-1:0] b);
        int n = 0;
        for (int i = 0; i < int'(WL); i++) if (b[i]) n = i + 1;
        return n;
    endfunction

    // One full operation; called and returns at a falling edge with the controller idle
    task automatic do_op(input logic [WL-1:0] a, input logic [WL-1:0] b, input int hold);
        logic [PW-1:0] exp_res;
        int            exp_iters, exp_lat, lat, nshift;
        logic [WL-1:0] adds;
        bit            seen;
        exp_res = PW'(a) * PW'(b);
`ifdef SMUL_EARLY_EXIT_EN
        exp_iters = sig_bits(b);
        exp_lat   = (exp_iters == int'(WL)) ? int'(WL) + 3 : exp_iters + 4;
`else
        exp_iters = int'(WL);
        exp_lat   = int'(WL) + 3;
`endif
        check("in_ready_idle", 64'(IN_READY), 64'(1));
        IN_VALID = 1'b1; OP_A = a; OP_B = b;
        @(posedge CLK);
        @(negedge CLK);
        IN_VALID = 1'b0; OP_A = WL'($urandom); OP_B = WL'($urandom);
        lat = 1; nshift = 0; adds = '0; seen = 1'b0;
        while (!seen && lat < 50) begin
            if (OUT_VALID) begin
                seen = 1'b1;
            end else begin
                if (DP_SHIFT) begin
                    if (nshift < int'(WL)) adds[nshift] = DP_ADD;
                    nshift++;
                end
                OUT_READY = 1'($urandom);
                @(negedge CLK);
                lat++;
            end
        end
        OUT_READY = 1'b0;
        check("out_valid_seen", 64'(seen), 64'(1));
        check("latency", 64'(lat), 64'(exp_lat));
        check("add_pattern", 64'(adds), 64'(b));
        check("shift_count", 64'(nshift), 64'(exp_iters));
        check("result", 64'(RESULT), 64'(exp_res));
        check("iters", 64'(ITERS), 64'(exp_iters));
        check("in_ready_done", 64'(IN_READY), 64'(0));
        check("dp_a_latched", 64'(DP_A), 64'(a));
        repeat (hold) begin
            @(negedge CLK);
            check("hold_valid", 64'(OUT_VALID), 64'(1));
            check("hold_result", 64'(RESULT), 64'(exp_res));
            check("hold_in_ready", 64'(IN_READY), 64'(0));
        end
        OUT_READY = 1'b1;
        @(negedge CLK);
        OUT_READY = 1'b0;
        check("idle_in_ready", 64'(IN_READY), 64'(1));
        check("idle_out_valid", 64'(OUT_VALID), 64'(0));
        check("idle_result_kept", 64'(RESULT), 64'(exp_res));
        last_res   = exp_res;
        last_iters = CW'(exp_iters);
        last_a     = PW'(a);
        last_b     = PW'(b);
    endtask

    // Abort in the second RUN cycle: back to idle, nothing delivered, old result kept
    task automatic abort_mid_run();
        int vcount = 0;
        IN_VALID = 1'b1; OP_A = 4'd5; OP_B = 4'd6;
        @(posedge CLK);
        @(negedge CLK);
        IN_VALID = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        ABORT = 1'b1;
        @(negedge CLK);
        ABORT = 1'b0;
        check("abort_in_ready", 64'(IN_READY), 64'(1));
        check("abort_out_valid", 64'(OUT_VALID), 64'(0));
        check("abort_result_kept", 64'(RESULT), 64'(last_res));
        check("abort_iters_kept", 64'(ITERS), 64'(last_iters));
        repeat (WL + 4) begin
            @(negedge CLK);
            if (OUT_VALID) vcount++;
        end
        check("abort_no_valid", 64'(vcount), 64'(0));
        last_a = PW'(5);
        last_b = PW'(6);
    endtask

    // Abort coinciding with an accept: operands must not be latched
    task automatic abort_at_accept();
        IN_VALID = 1'b1; ABORT = 1'b1; OP_A = 4'd9; OP_B = 4'd10;
        @(negedge CLK);
        IN_VALID = 1'b0; ABORT = 1'b0;
        check("abort_acc_in_ready", 64'(IN_READY), 64'(1));
        check("abort_acc_dp_a", 64'(DP_A), 64'(last_a));
        check("abort_acc_dp_b", 64'(DP_B), 64'(last_b));
        @(negedge CLK);
        check("abort_acc_no_load", 64'(DP_LOAD), 64'(0));
    endtask

    // Asynchronous reset in the middle of RUN
    task automatic reset_mid_run();
        IN_VALID = 1'b1; OP_A = 4'd7; OP_B = 4'd3;
        @(posedge CLK);
        @(negedge CLK);
        IN_VALID = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        #2 RST_N = 1'b0;
        #1;
        check("rst_in_ready", 64'(IN_READY), 64'(1));
        check("rst_out_valid", 64'(OUT_VALID), 64'(0));
        check("rst_result", 64'(RESULT), 64'(0));
        check("rst_iters", 64'(ITERS), 64'(0));
        check("rst_dp_a", 64'(DP_A), 64'(0));
        check("rst_dp_b", 64'(DP_B), 64'(0));
        check("rst_strobes", 64'({DP_LOAD, DP_CLR, DP_ADD, DP_SHIFT}), 64'(0));
        @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);
        check("rst_release_ready", 64'(IN_READY), 64'(1));
        last_res = '0; last_iters = '0; last_a = '0; last_b = '0;
    endtask

    initial begin
        RST_N = 1'b0; IN_VALID = 1'b0; ABORT = 1'b0; OUT_READY = 1'b0;
        OP_A = '0; OP_B = '0;
        last_res = '0; last_iters = '0; last_a = '0; last_b = '0;
        repeat (2) @(negedge CLK);
        check("reset_in_ready", 64'(IN_READY), 64'(1));
        check("reset_out_valid", 64'(OUT_VALID), 64'(0));
        check("reset_result", 64'(RESULT), 64'(0));
        check("reset_iters", 64'(ITERS), 64'(0));
        check("reset_strobes", 64'({DP_LOAD, DP_CLR, DP_ADD, DP_SHIFT}), 64'(0));
        RST_N = 1'b1;
        @(negedge CLK);

        do_op(4'd13, 4'd11, 0);
        do_op(4'd15, 4'd15, 10);
        do_op(4'd0, 4'd9, 2);
        abort_mid_run();
        abort_at_accept();
        do_op(4'd3, 4'd5, 0);
        reset_mid_run();
        do_op(4'd7, 4'd2, 1);
        do_op(4'd6, 4'd0, 0);
        for (int i = 0; i < 24; i++) begin
            do_op(WL'($urandom), WL'($urandom), int'($urandom_range(0, 3)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
